// File: rtl/requant_pipe.sv
// Requantiser: CH lanes of IN_W-bit signed accumulators -> OUT_W-bit signed data.
// Two register stages (bias add, shift/clamp) with valid/ready backpressure and saturation status.
module requant_pipe #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16,
  parameter int CH    = 4,
  parameter int SH_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  In_valid,
  output logic                  In_ready,
  input  logic [CH*IN_W-1:0]    Data_in,
  input  logic [SH_W-1:0]       Shift,
  input  logic [1:0]            Mode,
  input  logic                  Sat_en,
  output logic                  Out_valid,
  input  logic                  Out_ready,
  output logic [CH*OUT_W-1:0]   Data_out,
  output logic                  Sat_flag,
  input  logic                  Sat_clr,
  output logic [15:0]           Sat_cnt
);

  localparam int SUM_W = IN_W + 1;
  localparam logic signed [SUM_W-1:0] C_MAX = SUM_W'((longint'(1) <<< (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] C_MIN = ~C_MAX;

  logic            w_s1_load;
  logic            w_s2_load;
  logic            r_s1_valid;
  logic            r_s1_sat;
  logic [SH_W-1:0] r_s1_shift;
  logic            r_s2_valid;
  logic            r_s2_clamp;
  logic [CH-1:0]   w_clamp;
  logic            r_sat_flag;
  logic [15:0]     r_sat_cnt;

  assign w_s2_load = !r_s2_valid || Out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign In_ready  = w_s1_load;
  assign Out_valid = r_s2_valid;
  assign Sat_flag  = r_sat_flag;
  assign Sat_cnt   = r_sat_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_lane
      logic signed [SUM_W-1:0] w_x;
      logic signed [SUM_W-1:0] w_half;
      logic signed [SUM_W-1:0] w_bias;
      logic signed [SUM_W-1:0] w_sum;
      logic signed [SUM_W-1:0] w_shifted;
      logic signed [SUM_W-1:0] r_sum;
      logic                    w_tie;
      logic                    w_hi;
      logic                    w_lo;
      logic [OUT_W-1:0]        w_res;
      logic [OUT_W-1:0]        r_out;

      assign w_x    = {Data_in[gi*IN_W + IN_W - 1], Data_in[gi*IN_W +: IN_W]};
      assign w_half = SUM_W'(1) << (Shift - SH_W'(1));
      // Bit just above the discarded fraction; adding it makes exact halves land on even.
      assign w_tie  = |(w_x & (SUM_W'(1) << Shift));

      always_comb begin
        w_bias = '0;
        if (Shift != '0) begin
          if (Mode == 2'd1)      w_bias = w_half;
          else if (Mode == 2'd2) w_bias = w_half - SUM_W'(1) + SUM_W'(w_tie);
        end
      end

      assign w_sum     = w_x + w_bias;
      assign w_shifted = r_sum >>> r_s1_shift;
      assign w_hi      = w_shifted > C_MAX;
      assign w_lo      = w_shifted < C_MIN;
      assign w_clamp[gi] = r_s1_sat && (w_hi || w_lo);

      always_comb begin
        w_res = w_shifted[OUT_W-1:0];
        if (r_s1_sat && w_hi)      w_res = C_MAX[OUT_W-1:0];
        else if (r_s1_sat && w_lo) w_res = C_MIN[OUT_W-1:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sum <= '0;
          r_out <= '0;
        end else begin
          if (w_s1_load && In_valid)   r_sum <= w_sum;
          if (w_s2_load && r_s1_valid) r_out <= w_res;
        end
      end

      assign Data_out[gi*OUT_W +: OUT_W] = r_out;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sat   <= 1'b0;
      r_s1_shift <= '0;
      r_s2_valid <= 1'b0;
      r_s2_clamp <= 1'b0;
      r_sat_flag <= 1'b0;
      r_sat_cnt  <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= In_valid;
        if (In_valid) begin
          r_s1_shift <= Shift;
          r_s1_sat   <= Sat_en;
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        r_s2_clamp <= |w_clamp;
      end
      // Status moves only when a clamped beat actually leaves; clear wins.
      if (Sat_clr) begin
        r_sat_flag <= 1'b0;
        r_sat_cnt  <= '0;
      end else if (r_s2_valid && Out_ready && r_s2_clamp) begin
        r_sat_flag <= 1'b1;
        if (r_sat_cnt != 16'hFFFF) r_sat_cnt <= r_sat_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_requant_pipe.sv
// Bench for requant_pipe: arithmetic reference model with a per-cycle checker,
// plus directed beats whose results are pinned by hand-computed constants.
module tb_requant_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        In_valid = 1'b0;
  logic        In_ready;
  logic [95:0] Data_in = '0;
  logic [4:0]  Shift = '0;
  logic [1:0]  Mode = '0;
  logic        Sat_en = 1'b0;
  logic        Out_valid;
  logic        Out_ready = 1'b1;
  logic [63:0] Data_out;
  logic        Sat_flag;
  logic        Sat_clr = 1'b0;
  logic [15:0] Sat_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  requant_pipe #(.IN_W(24), .OUT_W(16), .CH(4), .SH_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .In_valid(In_valid), .In_ready(In_ready),
    .Data_in(Data_in), .Shift(Shift), .Mode(Mode), .Sat_en(Sat_en),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Data_out(Data_out),
    .Sat_flag(Sat_flag), .Sat_clr(Sat_clr), .Sat_cnt(Sat_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [63:0] d;
    bit          clamp;
    int          t_in;
  } item_t;

  // Floor division, then round on the exact remainder; clamp or wrap to 16 bits.
  function automatic logic [15:0] model_lane(input longint x, input int s, input int m,
                                             input bit sat, output bit clamp);
    longint p, q, r, y;
    p = longint'(1) << s;
    q = x / p;
    if ((x % p) != 0 && x < 0) q = q - 1;
    r = x - q * p;
    y = q;
    if (s > 0) begin
      if (m == 1 && 2 * r >= p) y = q + 1;
      if (m == 2 && (2 * r > p || (2 * r == p && q[0]))) y = q + 1;
    end
    clamp = 1'b0;
    if (sat && y > 32767) begin
      y = 32767; clamp = 1'b1;
    end else if (sat && y < -32768) begin
      y = -32768; clamp = 1'b1;
    end
    return y[15:0];
  endfunction

  function automatic item_t model_beat(input logic [95:0] d, input logic [4:0] s,
                                       input logic [1:0] m, input logic se);
    item_t it;
    logic signed [23:0] lv;
    bit c;
    it.d = '0;
    it.clamp = 1'b0;
    it.t_in = 0;
    for (int i = 0; i < 4; i++) begin
      lv = d[i*24 +: 24];
      it.d[i*16 +: 16] = model_lane(longint'(lv), int'(s), int'(m), se, c);
      if (c) it.clamp = 1'b1;
    end
    return it;
  endfunction

  item_t       q[$];
  logic [63:0] out_log[$];
  int          last_lat = -1;
  int          head_lat = 0;
  bit          head_seen = 1'b0;
  bit          stall_pend = 1'b0;
  logic [63:0] stall_data = '0;
  bit          st_flag = 1'b0;
  int          st_cnt = 0;

  // Single compare process: all handshakes are evaluated here, away from the rising edge.
  always @(negedge clk) begin
    item_t it;
    bit xfer_clamp;
    if (!rst_n) begin
      q.delete();
      head_seen = 1'b0;
      stall_pend = 1'b0;
      st_flag = 1'b0;
      st_cnt = 0;
      check("rst_out_valid", Out_valid, 0);
      check("rst_data_out", Data_out, 0);
    end else begin
      check("in_ready", In_ready, !(q.size() == 2 && !Out_ready));
      if (stall_pend) begin
        check("stall_valid", Out_valid, 1);
        check("stall_data", Data_out, stall_data);
      end
      check("sat_cnt", Sat_cnt, st_cnt);
      check("sat_flag", Sat_flag, st_flag);
      xfer_clamp = 1'b0;
      if (Out_valid && q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else if (Out_valid) begin
        if (!head_seen) begin
          head_seen = 1'b1;
          head_lat = cyc - q[0].t_in;
        end
        if (Out_ready) begin
          it = q.pop_front();
          check("data_out", Data_out, it.d);
          out_log.push_back(Data_out);
          last_lat = head_lat;
          head_seen = 1'b0;
          xfer_clamp = it.clamp;
        end
      end
      stall_pend = Out_valid && !Out_ready;
      stall_data = Data_out;
      if (Sat_clr) begin
        st_flag = 1'b0;
        st_cnt = 0;
      end else if (xfer_clamp) begin
        st_flag = 1'b1;
        if (st_cnt < 65535) st_cnt++;
      end
      if (In_valid && In_ready) begin
        it = model_beat(Data_in, Shift, Mode, Sat_en);
        it.t_in = cyc;
        q.push_back(it);
      end
    end
  end

  // Call at 1 time unit after a rising edge; returns at the same phase after the transfer.
  task automatic send(input logic [95:0] d, input logic [4:0] s, input logic [1:0] m,
                      input logic se);
    bit ok = 1'b0;
    Data_in = d; Shift = s; Mode = m; Sat_en = se; In_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = In_ready;
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    In_valid = 1'b0;
  endtask

  task automatic wait_out(input int target);
    for (int k = 0; k < 200 && out_log.size() < target; k++) @(posedge clk);
    #1;
    if (out_log.size() < target) check("out_timeout", out_log.size(), target);
  endtask

  logic [95:0] rnd_data = 96'h000080_FFFE80_000280_000180;
  logic [63:0] rnd_exp [4] = '{64'h0000_FFFE_0002_0001, 64'h0001_FFFF_0003_0002,
                               64'h0000_FFFE_0002_0002, 64'h0000_FFFE_0002_0001};
  logic [95:0] bp_data [6] = '{96'h000001_7FFF00_800100_123456, 96'hFFFFFF_000010_0ABCDE_FFF001,
                               96'h00FF00_FF00FF_001000_000800, 96'h3FFFFF_C00000_000003_FFFFFD,
                               96'h000000_00ABCD_FFFFFF_000042, 96'h765432_89ABCD_000100_FFFF00};
  logic [4:0]  bp_sh [6] = '{5'd8, 5'd4, 5'd12, 5'd1, 5'd0, 5'd16};
  logic [1:0]  bp_md [6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd3};
  bit          or_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [95:0] sat_data = 96'h000000_000123_800000_7FFFFF;

  initial begin
    int base;
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", In_ready, 1);
    check("reset_out_valid", Out_valid, 0);
    check("reset_data_out", Data_out, 0);
    check("reset_sat_flag", Sat_flag, 0);
    check("reset_sat_cnt", Sat_cnt, 0);
    @(posedge clk);
    #1;

    // Legacy Data_in[23:8] slice
    base = out_log.size();
    send(96'h000000_000000_FEDCBA_123456, 5'd8, 2'd0, 1'b0);
    wait_out(base + 1);
    check("legacy_lane0", out_log[base][15:0], 16'h1234);
    check("legacy_lane1", out_log[base][31:16], 16'hFEDC);
    check("legacy_latency", last_lat, 2);

    // Rounding modes 0..3, back to back
    base = out_log.size();
    for (int m = 0; m < 4; m++) send(rnd_data, 5'd8, 2'(m), 1'b0);
    wait_out(base + 4);
    for (int m = 0; m < 4; m++) check($sformatf("round_mode%0d", m), out_log[base+m], rnd_exp[m]);

    // Saturation on, then the same beat wrapping
    base = out_log.size();
    send(sat_data, 5'd4, 2'd0, 1'b1);
    wait_out(base + 1);
    check("sat_clamp", out_log[base], 64'h0000_0012_8000_7FFF);
    check("sat_flag_set", Sat_flag, 1);
    check("sat_cnt_one", Sat_cnt, 1);
    send(sat_data, 5'd4, 2'd0, 1'b0);
    wait_out(base + 2);
    check("sat_wrap", out_log[base+1], 64'h0000_0012_0000_FFFF);
    check("wrap_cnt_same", Sat_cnt, 1);

    // Backpressure with Out_ready cycling 1,0,0,1,1
    base = out_log.size();
    fork
      begin
        for (int i = 0; i < 6; i++) send(bp_data[i], bp_sh[i], bp_md[i], 1'b0);
      end
      begin
        for (int c = 0; c < 30; c++) begin
          Out_ready = or_pat[c % 5];
          @(posedge clk);
          #1;
        end
        Out_ready = 1'b1;
      end
    join
    wait_out(base + 6);
    check("bp_count", out_log.size(), base + 6);
    check("bp_first", out_log[base][15:0], 16'h1234);

    // Status clear racing a saturating transfer
    send(sat_data, 5'd4, 2'd1, 1'b1);
    send(sat_data, 5'd4, 2'd2, 1'b1);
    wait_out(base + 8);
    check("sat_cnt_three", Sat_cnt, 3);
    Out_ready = 1'b0;
    send(sat_data, 5'd4, 2'd0, 1'b1);
    seen = Out_valid;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = Out_valid;
    end
    check("clr_beat_valid", seen, 1);
    Sat_clr = 1'b1;
    Out_ready = 1'b1;
    @(posedge clk);
    #1;
    Sat_clr = 1'b0;
    check("clr_cnt", Sat_cnt, 0);
    check("clr_flag", Sat_flag, 0);

    // Reset with two beats held
    Out_ready = 1'b0;
    send(96'h111111_222222_333333_444444, 5'd4, 2'd0, 1'b0);
    send(96'h555555_666666_777777_888888, 5'd4, 2'd0, 1'b0);
    check("pre_rst_valid", Out_valid, 1);
    base = out_log.size();
    rst_n = 1'b0;
    #1;
    check("async_out_valid", Out_valid, 0);
    check("async_data_out", Data_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    Out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", In_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    check("no_stale_beat", out_log.size(), base);
    check("drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
